dac_mix_scheduler: RTL
======================

// Module: dac_mix_scheduler
// PURPOSE
//  Sample-rate scheduler and mixer in front of the 12-bit first-order delta-sigma DAC.
//  Captures offset-binary 12-bit samples from NVOICE voice generators via valid/ready.
//  Once per sample period, sums the voices in time-multiplexed form (one adder, one voice per cycle).
//  Clamps the sum, applies a pop-free mute/unmute gain ramp, and presents the result on dac_din.
// PARAMETERS
//  NVOICE      3     number of voice inputs, legal range 1..4
//  SAMPLE_DIV  1134  clk cycles per output sample (50 MHz / 1134 = 44.09 kHz); must be >= NVOICE+3
//  RAMP_STEP   1     gain increment/decrement per sample; gain range 0..256
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  enable         in   1          1 = ramp gain up to unity; 0 = ramp gain down to mute
//  v_data         in   12*NVOICE  voice samples, offset binary; voice i at [12*i+11:12*i]
//  v_valid        in   NVOICE     voice i presents a new sample
//  v_ready        out  NVOICE     voice i may transfer
//  sample_tick    out  1          one-cycle pulse at each sample-period boundary
//  dac_din        out  12         offset-binary sample to the delta-sigma DAC
//  dac_strobe     out  1          one-cycle pulse in the cycle dac_din updates
//  muted          out  1          1 while gain == 0
//  overrun        out  NVOICE     sticky: voice i delivered >1 sample in one period
// BEHAVIOUR
//  Reset values:
//   - dac_din = 12'h800 (midscale); gain = 0; muted = 1.
//   - sample_tick = 0; dac_strobe = 0; overrun = 0; v_ready = 0.
//   - divider = 0; FSM = IDLE; all voice hold registers = 12'h800.
//  Divider:
//   - counts 0..SAMPLE_DIV-1 and wraps.
//   - sample_tick = 1 in the cycle the divider equals SAMPLE_DIV-1.
//  Voice capture:
//   - v_ready = all ones from the first cycle after reset.
//   - On v_valid[i] & v_ready[i], hold[i] <= v_data[i].
//   - A second transfer by voice i within the same sample period sets overrun[i]; the newer sample still wins.
//   - Per-voice transfer-seen flags clear on sample_tick.
//   - A voice that sends no sample in a period keeps its previous hold value.
//  FSM:
//   - IDLE: wait for sample_tick. On tick, snapshot all hold[] into snap[], acc <= 0, go to MIX with k = 0.
//     A transfer in the tick cycle lands in hold, not snap.
//   - MIX, NVOICE cycles: acc <= acc + (snap[k] - 2048), signed 14-bit; k++. Go to SCALE after k = NVOICE-1.
//   - SCALE, 1 cycle: m = clamp(acc, -2048, +2047); p = m * gain, signed 21-bit; go to OUT.
//   - OUT, 1 cycle: dac_din <= (p >>> 8) + 2048 (arithmetic shift, floor); dac_strobe = 1.
//     Gain updates after use in this cycle:
//       - enable = 1: gain = min(gain + RAMP_STEP, 256)
//       - enable = 0: gain = max(gain - RAMP_STEP, 0)
//     Return to IDLE.
//  Latency: dac_din changes exactly NVOICE+2 cycles after the sample_tick cycle. One update per period.
//  Gain semantics:
//   - gain = 256 means unity; the output equals the clamped mix exactly.
//   - gain = 0 gives dac_din = 12'h800.
//  muted = (gain == 0), registered, valid from the cycle after OUT.
//  enable toggled mid-ramp: the ramp reverses from the current gain; no jump.
//  rst asserted mid-sequence: abort and return to reset values next cycle; no partial dac_din update.
// TESTING
//  1 Reset: hold rst 3 cycles -> dac_din=12'h800, muted=1, overrun=0, dac_strobe=0, then v_ready=all 1s.
//  2 Ramp, SAMPLE_DIV=8, NVOICE=3, enable=1, all voices 12'hFFF:
//    -> gain reaches 256 after 256 strobes, muted falls after the 1st strobe.
//    -> final dac_din = 12'hFFF (sum 6141 clamped to 2047).
//  3 Mix at unity gain, voices 12'h900/12'h900/12'h700 -> dac_din = 12'h900 (+256 +256 -256).
//  4 Negative clamp at unity gain, all voices 12'h000 -> dac_din = 12'h000 (sum -6144 clamped to -2048).
//  5 Overrun: voice 1 pulses v_valid twice within one period -> overrun = 3'b010, sticky until rst.
//    The second sample is used in the mix.
//  6 Timing, SAMPLE_DIV=8:
//    -> sample_tick every 8 cycles.
//    -> dac_strobe exactly 5 cycles after each tick.
//    -> enable dropped at gain=100 -> gain falls 99, 98, ... to 0; dac_din returns to 12'h800.

Source files
------------

// File: rtl/dac_mix_if.sv
// Voice handshake and DAC-side signals of the mixer scheduler.
// The master modport is the voice/control side; slave is the scheduler.
interface dac_mix_if #(
    parameter int unsigned NVOICE = 3
);
    logic                   enable;
    logic [12*NVOICE-1:0]   v_data;
    logic [NVOICE-1:0]      v_valid;
    logic [NVOICE-1:0]      v_ready;
    logic                   sample_tick;
    logic [11:0]            dac_din;
    logic                   dac_strobe;
    logic                   muted;
    logic [NVOICE-1:0]      overrun;

    modport master (
        output enable, v_data, v_valid,
        input  v_ready, sample_tick, dac_din, dac_strobe, muted, overrun
    );

    modport slave (
        input  enable, v_data, v_valid,
        output v_ready, sample_tick, dac_din, dac_strobe, muted, overrun
    );
endinterface

// File: rtl/dac_mix_scheduler.sv
// Sample-rate scheduler and mixer feeding a 12-bit delta-sigma DAC: captures voices,
// sums them one per cycle each sample period, clamps, applies a mute ramp and outputs.
module dac_mix_scheduler #(
    parameter int unsigned NVOICE     = 3,
    parameter int unsigned SAMPLE_DIV = 1134,
    parameter int unsigned RAMP_STEP  = 1
) (
    input logic      clk,
    input logic      rst,
    dac_mix_if.slave bus
);
    localparam int unsigned DivW = $clog2(SAMPLE_DIV);
    localparam int unsigned KW   = (NVOICE > 1) ? $clog2(NVOICE) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMix   = 2'd1;
    localparam logic [1:0] StScale = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    logic [DivW-1:0]   div_q, div_d;
    logic              tick;

    logic [NVOICE-1:0] v_ready_q, v_ready_d;
    logic [NVOICE-1:0] seen_q, seen_d;
    logic [NVOICE-1:0] overrun_q, overrun_d;
    logic [NVOICE-1:0] xfer;
    logic [11:0]       hold_q [NVOICE];
    logic [11:0]       hold_d [NVOICE];
    logic [11:0]       snap_q [NVOICE];
    logic [11:0]       snap_d [NVOICE];

    logic [1:0]          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic signed [13:0]  acc_q, acc_d;
    logic signed [20:0]  p_q, p_d;
    logic [8:0]          gain_q, gain_d;
    logic [11:0]         dac_din_q, dac_din_d;
    logic                muted_q, muted_d;

    logic [11:0]         sel;
    logic signed [13:0]  voice_s;
    logic signed [11:0]  m;
    logic signed [21:0]  m_ext, g_ext, prod;
    logic signed [20:0]  p_shift;
    logic [11:0]         dac_val;
    logic [9:0]          gain_up;
    logic                strobe;
    logic                unused_bits;

    // Divider and per-period voice capture.
    assign tick = (div_q == DivW'(SAMPLE_DIV - 1));
    assign xfer = bus.v_valid & v_ready_q;

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        v_ready_d = '1;
        hold_d    = hold_q;
        for (int i = 0; i < NVOICE; i++) begin
            if (xfer[i]) begin
                hold_d[i] = bus.v_data[12*i +: 12];
            end
        end
        // A transfer in the tick cycle already belongs to the next period.
        seen_d    = tick ? xfer : (seen_q | xfer);
        overrun_d = overrun_q | (xfer & seen_q & {NVOICE{~tick}});
    end

    // Datapath: voice select, offset removal, clamp, gain multiply, output offset.
    always_comb begin
        sel = 12'h800;
        for (int i = 0; i < NVOICE; i++) begin
            if (k_q == KW'(i)) begin
                sel = snap_q[i];
            end
        end
    end

    assign voice_s = {{2{~sel[11]}}, ~sel[11], sel[10:0]};

    always_comb begin
        if (acc_q > 14'sd2047) begin
            m = 12'sd2047;
        end else if (acc_q < -14'sd2048) begin
            m = -12'sd2048;
        end else begin
            m = acc_q[11:0];
        end
    end

    assign m_ext   = 22'(m);
    assign g_ext   = 22'($signed({1'b0, gain_q}));
    assign prod    = m_ext * g_ext;
    assign p_shift = p_q >>> 8;
    assign dac_val = p_shift[11:0] + 12'h800;
    assign gain_up = {1'b0, gain_q} + 10'(RAMP_STEP);
    assign strobe  = (state_q == StOut);

    assign unused_bits = ^{prod[21], p_shift[20:12]};

    // Sequencer: IDLE -> MIX (NVOICE cycles) -> SCALE -> OUT -> IDLE.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        p_d       = p_q;
        gain_d    = gain_q;
        dac_din_d = dac_din_q;
        snap_d    = snap_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    snap_d  = hold_q;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StMix;
                end
            end
            StMix: begin
                acc_d = acc_q + voice_s;
                if (k_q == KW'(NVOICE - 1)) begin
                    state_d = StScale;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StScale: begin
                p_d     = prod[20:0];
                state_d = StOut;
            end
            StOut: begin
                dac_din_d = dac_val;
                if (bus.enable) begin
                    gain_d = (gain_up > 10'd256) ? 9'd256 : gain_up[8:0];
                end else begin
                    gain_d = (gain_q < 9'(RAMP_STEP)) ? 9'd0 : gain_q - 9'(RAMP_STEP);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        muted_d = (gain_d == 9'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            v_ready_q <= '0;
            seen_q    <= '0;
            overrun_q <= '0;
            state_q   <= StIdle;
            k_q       <= '0;
            acc_q     <= '0;
            p_q       <= '0;
            gain_q    <= '0;
            dac_din_q <= 12'h800;
            muted_q   <= 1'b1;
            for (int i = 0; i < NVOICE; i++) begin
                hold_q[i] <= 12'h800;
                snap_q[i] <= 12'h800;
            end
        end else begin
            div_q     <= div_d;
            v_ready_q <= v_ready_d;
            seen_q    <= seen_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            p_q       <= p_d;
            gain_q    <= gain_d;
            dac_din_q <= dac_din_d;
            muted_q   <= muted_d;
            hold_q    <= hold_d;
            snap_q    <= snap_d;
        end
    end

    // The new sample is visible in the strobe cycle itself and held afterwards.
    assign bus.dac_din     = strobe ? dac_val : dac_din_q;
    assign bus.dac_strobe  = strobe;
    assign bus.sample_tick = tick;
    assign bus.v_ready     = v_ready_q;
    assign bus.overrun     = overrun_q;
    assign bus.muted       = muted_q;
endmodule
